hls_start_arbiter: RTL and testbench

- Shares a single HLS accelerator core's start/finish handshake between NUM_REQ requesters (UART command decoder, test-pattern source, etc.).
- Latches one-cycle start requests and grants the core round-robin, one job at a time.
- Issues a one-cycle hls_start pulse, waits for hls_finish, then returns a done pulse to the granted requester.
- Sits between the request sources and the HLS core's start/finish ports.

---
 rtl/hls_start_arbiter_pkg.sv | 18 +
 rtl/hls_start_arbiter_rr_pick.sv | 31 +++
 rtl/hls_start_arbiter.sv | 133 +++++++++++++
 tb/tb_hls_start_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_start_arbiter_pkg.sv
// Shared definitions for the HLS start arbiter: FSM state encoding and a
// constant-foldable clog2 used for parameter sanity checks.
package hls_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/hls_start_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of pending at or after ptr,
// wrapping modulo NUM_REQ. Outputs one-hot, binary index and a found flag.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   int j;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      j      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (!any && pending[j]) begin
            any       = 1'b1;
            onehot[j] = 1'b1;
            idx       = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/hls_start_arbiter.sv
// Round-robin sharing of one HLS core start/finish handshake among NUM_REQ
// requesters. Optional RUN watchdog: define HLS_START_ARBITER_TIMEOUT_EN.
module hls_start_arbiter
   import hls_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TO_W           = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               hls_finish,
   output logic               hls_start,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    active_id,
   output logic [NUM_REQ-1:0] done,
   output logic               busy,
   output logic               timeout_err
);

   if (ID_W != clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 ||
       (64'(1) << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
      $error("hls_start_arbiter: inconsistent NUM_REQ/ID_W/TO_W/TIMEOUT_CYCLES");
   end

   state_t             state, state_nxt;
   logic [NUM_REQ-1:0] pending, pending_nxt;
   logic [NUM_REQ-1:0] grant_nxt, done_nxt;
   logic [ID_W-1:0]    ptr, ptr_nxt, active_nxt;
   logic [NUM_REQ-1:0] pick_oh;
   logic [ID_W-1:0]    pick_idx;
   logic               pick_any;
   logic               rereq, rereq_nxt;
   logic               job_end;
   logic               expire;

   rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
      .pending (pending),
      .ptr     (ptr),
      .onehot  (pick_oh),
      .idx     (pick_idx),
      .any     (pick_any)
   );

`ifdef HLS_START_ARBITER_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;
   logic            to_err;

   // cnt holds the number of RUN cycles already completed
   assign expire = (state == ST_RUN) && !hls_finish &&
                   (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt <= '0;
         to_err <= 1'b0;
      end else begin
         to_err <= expire;
         if (state == ST_START)    to_cnt <= '0;
         else if (state == ST_RUN) to_cnt <= to_cnt + TO_W'(1);
      end
   end

   assign timeout_err = to_err;
`else
   assign expire      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending | req;
      grant_nxt   = grant;
      active_nxt  = active_id;
      done_nxt    = '0;
      ptr_nxt     = ptr;
      rereq_nxt   = rereq;
      job_end     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               grant_nxt  = pick_oh;
               active_nxt = pick_idx;
               rereq_nxt  = 1'b0;
               state_nxt  = ST_START;
            end
         end
         ST_START: begin
            rereq_nxt = rereq | req[active_id];
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            rereq_nxt = rereq | req[active_id];
            job_end   = hls_finish | expire;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Owner requests seen after the grant survive the clear and queue a rerun.
      if (job_end) begin
         done_nxt[active_id]    = 1'b1;
         pending_nxt[active_id] = rereq | req[active_id];
         ptr_nxt   = (active_id == ID_W'(NUM_REQ - 1)) ? '0 : active_id + ID_W'(1);
         grant_nxt = '0;
         state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         pending   <= '0;
         grant     <= '0;
         active_id <= '0;
         done      <= '0;
         ptr       <= '0;
         rereq     <= 1'b0;
      end else begin
         state     <= state_nxt;
         pending   <= pending_nxt;
         grant     <= grant_nxt;
         active_id <= active_nxt;
         done      <= done_nxt;
         ptr       <= ptr_nxt;
         rereq     <= rereq_nxt;
      end
   end

   assign busy      = (state != ST_IDLE);
   assign hls_start = (state == ST_START);

endmodule

// File: tb/tb_hls_start_arbiter.sv
// Scoreboard bench for hls_start_arbiter: a set-based job model predicts
// start/done events; a negedge monitor pops and compares them.
module tb_hls_start_arbiter;
   localparam int N  = 4;
   localparam int IW = 2;
`ifdef HLS_START_ARBITER_TIMEOUT_EN
   localparam int TO_LIM = 16;
   localparam int TOW    = 5;
`else
   localparam int TO_LIM = 1000000;
   localparam int TOW    = 20;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          hls_finish = 1'b0;
   logic [N-1:0]  req = '0;
   logic          hls_start, busy, timeout_err;
   logic [N-1:0]  grant, done;
   logic [IW-1:0] active_id;

   always #5 clk = ~clk;

   hls_start_arbiter #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT_CYCLES(TO_LIM), .TO_W(TOW)) dut (
      .clk(clk), .reset(reset), .req(req), .hls_finish(hls_finish),
      .hls_start(hls_start), .grant(grant), .active_id(active_id),
      .done(done), .busy(busy), .timeout_err(timeout_err)
   );

   typedef struct { int owner; int cyc; } st_exp_t;
   typedef struct { logic [N-1:0] vec; bit err; int cyc; } dn_exp_t;
   st_exp_t start_q[$];
   dn_exp_t done_q[$];
   int start_log[$];

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   bit mon_en = 0;
   // job-level model: owed = requesters that still deserve a job
   bit       m_busy = 0;
   int       m_owner = 0, m_start = 0, m_ptr = 0;
   bit [N-1:0] owed = '0;
   int last_start_cyc = 0, last_done_cyc = 0, n_done = 0, n_to = 0;
   // driver knobs
   int fin_mode = 0, fin_dly = 8, collide_left = 0, first_cyc = 0;
   bit spur_start = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int rr(input bit [N-1:0] p, input int ptr);
      for (int k = 0; k < N; k++)
         if (p[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic end_job(input bit err);
      dn_exp_t e;
      e.vec = N'(1) << m_owner;
      e.err = err;
      e.cyc = cyc;
      done_q.push_back(e);
      m_busy = 0;
      m_ptr  = (m_owner + 1) % N;
   endtask

   // model: evaluated at each rising edge using the values sampled there
   initial forever begin
      int g;
      bit [N-1:0] sr;
      @(posedge clk);
      cyc++;
      sr = req;
      g  = -1;
      if (reset) begin
         owed = '0; m_ptr = 0; m_busy = 0; mon_en = 1;
      end else begin
         if (!m_busy && owed != '0) begin
            g = rr(owed, m_ptr);
            m_busy = 1; m_owner = g; m_start = cyc;
            start_q.push_back('{g, cyc});
         end else if (m_busy && cyc >= m_start + 2 && hls_finish) begin
            end_job(0);
         end
`ifdef HLS_START_ARBITER_TIMEOUT_EN
         else if (m_busy && cyc == m_start + TO_LIM + 1) begin
            end_job(1);
         end
`endif
         owed |= sr;
         if (g >= 0) owed[g] = 1'b0;
      end
   end

   // monitor
   initial forever begin
      st_exp_t s;
      dn_exp_t d;
      @(negedge clk);
      if (mon_en) begin
         check("busy", busy, m_busy);
         check("grant", grant, m_busy ? (64'(1) << m_owner) : 64'(0));
         if (hls_start === 1'b1) begin
            if (start_q.size() == 0) check("unexpected_start", 0, 1);
            else begin
               s = start_q.pop_front();
               check("start_id", active_id, s.owner);
               check("start_grant", grant, 64'(1) << s.owner);
               check("start_cyc", cyc, s.cyc);
               start_log.push_back(s.owner);
               last_start_cyc = cyc;
            end
         end
         if ((|done) === 1'b1 || timeout_err === 1'b1) begin
            if (done_q.size() == 0) check("unexpected_done", 0, 1);
            else begin
               d = done_q.pop_front();
               check("done_vec", done, d.vec);
               check("done_err", timeout_err, d.err);
               check("done_cyc", cyc, d.cyc);
               last_done_cyc = cyc;
               n_done++;
               if (timeout_err === 1'b1) n_to++;
            end
         end
      end
   end

   task automatic drive(input int n, input logic [N-1:0] first_req, input int rand_pct);
      logic [N-1:0] rq;
      logic fn;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (i == 0) first_cyc = cyc;
         rq = (i == 0) ? first_req : '0;
         for (int b = 0; b < N; b++)
            if (rand_pct > 0 && $urandom_range(99) < rand_pct) rq[b] = 1'b1;
         fn = 1'b0;
         if (m_busy && cyc >= m_start + 1) begin
            if (fin_mode == 1 && cyc >= m_start + fin_dly) fn = 1'b1;
            if (fin_mode == 2 && $urandom_range(3) == 0) fn = 1'b1;
         end else if (fin_mode == 2 && $urandom_range(15) == 0) fn = 1'b1;
         if (spur_start && m_busy && cyc == m_start) fn = 1'b1;
         if (collide_left > 0 && fn && m_owner == 2) begin
            rq[2] = 1'b1;
            collide_left--;
         end
         req = rq;
         hls_finish = fn;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; req = '0; hls_finish = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      int c2;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_active_id", active_id, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_hls_start", hls_start, 0);
      check("rst_done", done, 0);

      // idle hold
      fin_mode = 0;
      drive(20, '0, 0);
      check("idle_no_start", start_log.size(), 0);

      // single job: req cycle 0 -> start cycle 2, finish cycle 10 -> done cycle 11
      fin_mode = 1; fin_dly = 8;
      drive(16, 4'b0010, 0);
      check("single_count", start_log.size(), 1);
      check("single_owner", start_log[0], 1);
      check("single_start_lat", last_start_cyc - first_cyc, 2);
      check("single_done_lat", last_done_cyc - first_cyc, 11);

      // round robin from a fresh pointer
      do_reset();
      start_log.delete();
      fin_dly = 5;
      drive(40, 4'b1111, 0);
      check("rr_count", start_log.size(), 4);
      for (int i = 0; i < 4 && i < start_log.size(); i++) check("rr_order", start_log[i], i);

      // owner re-request coinciding with its finish
      do_reset();
      start_log.delete();
      collide_left = 1; fin_dly = 4;
      drive(30, 4'b0100, 0);
      c2 = 0;
      foreach (start_log[i]) if (start_log[i] == 2) c2++;
      check("collide_reruns", c2, 2);

      // spurious finish in IDLE, then in the START cycle
      do_reset();
      start_log.delete();
      n_done = 0;
      @(posedge clk); #1 hls_finish = 1'b1;
      @(posedge clk); #1 hls_finish = 1'b0;
      spur_start = 1; fin_dly = 3;
      drive(15, 4'b0001, 0);
      spur_start = 0;
      check("spur_starts", start_log.size(), 1);
      check("spur_dones", n_done, 1);
      check("spur_run_len", last_done_cyc - last_start_cyc, 4);

`ifdef HLS_START_ARBITER_TIMEOUT_EN
      do_reset();
      n_to = 0; fin_mode = 0;
      drive(30, 4'b0100, 0);
      check("wd_count", n_to, 1);
      check("wd_latency", last_done_cyc - last_start_cyc, TO_LIM + 1);
`endif

      // randomized traffic, then drain
      fin_mode = 2;
      drive(1500, '0, 8);
      for (int i = 0; i < 300 && (m_busy || owed != '0); i++) drive(1, '0, 0);
      check("drain_idle", m_busy, 0);
      fin_mode = 0;
      drive(4, '0, 0);
      check("start_q_empty", start_q.size(), 0);
      check("done_q_empty", done_q.size(), 0);

      // reset in the middle of a job drops it silently
      do_reset();
      drive(8, 4'b1000, 0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_grant", grant, 0);
      check("mid_rst_start", hls_start, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_id", active_id, 0);
      check("mid_rst_err", timeout_err, 0);
      reset = 1'b0;
      n_done = 0;
      drive(10, '0, 0);
      check("mid_rst_no_done", n_done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end
endmodule
